// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit/receive path and display.
package uart_pkg;

    localparam int unsigned UART_BUF_DEPTH = 4;

    typedef logic [7:0] uart_byte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } tx_sched_state_e;

endpackage

// File: rtl/shift_fifo.sv
// Shift-register FIFO: entry 0 is the head, pop shifts down, load writes at count.
module shift_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_BUF_DEPTH,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    pop,
    output logic [CNT_W-1:0]        count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow,
    output logic [DATA_W-1:0]       head,
    output logic [DEPTH*DATA_W-1:0] snap
);

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] mem_nxt [DEPTH];
    logic [CNT_W-1:0]  count_nxt;
    logic              overflow_nxt;

    // Pop-then-write ordering lets a load land in the slot freed by the same-cycle pop.
    always_comb begin
        mem_nxt      = mem;
        count_nxt    = count;
        overflow_nxt = 1'b0;
        if (pop && !empty) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_nxt[i] = mem[i+1];
            end
            mem_nxt[DEPTH-1] = '0;
            if (push) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CNT_W'(i) + CNT_W'(1) == count) mem_nxt[i] = push_data;
                end
            end else begin
                count_nxt = count - CNT_W'(1);
            end
        end else if (push) begin
            if (full) begin
                overflow_nxt = 1'b1;
            end else begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CNT_W'(i) == count) mem_nxt[i] = push_data;
                end
                count_nxt = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            mem      <= mem_nxt;
            count    <= count_nxt;
            full     <= (count_nxt == CNT_W'(DEPTH));
            empty    <= (count_nxt == '0);
            overflow <= overflow_nxt;
        end
    end

    assign head = mem[0];

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_snap
        assign snap[g*DATA_W +: DATA_W] = mem[g];
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: buffers switch bytes and feeds the byte transmitter via start/done.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH  = UART_BUF_DEPTH,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [DATA_W-1:0]       load_data_i,
    input  logic                    send_one_i,
    input  logic                    send_all_i,
    output logic                    tx_start_o,
    output logic [DATA_W-1:0]       tx_data_o,
    input  logic                    tx_busy_i,
    input  logic                    tx_done_i,
    output logic [CNT_W-1:0]        count_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    overflow_o,
    output logic                    sending_o,
    output logic [DEPTH*DATA_W-1:0] snap_o
);

    localparam logic [1:0] ST_IDLE      = 2'(IDLE);
    localparam logic [1:0] ST_ISSUE     = 2'(ISSUE);
    localparam logic [1:0] ST_WAIT_DONE = 2'(WAIT_DONE);

    logic [1:0]        state, state_nxt;
    logic              burst, burst_nxt;
    logic              start_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              pop;
    logic [DATA_W-1:0] head;

    shift_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (load_i),
        .push_data (load_data_i),
        .pop       (pop),
        .count     (count_o),
        .full      (full_o),
        .empty     (empty_o),
        .overflow  (overflow_o),
        .head      (head),
        .snap      (snap_o)
    );

    // Start pulse and data are registered on entry to ISSUE so they appear during ISSUE.
    always_comb begin
        state_nxt = state;
        burst_nxt = burst;
        start_nxt = 1'b0;
        data_nxt  = tx_data_o;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((send_one_i || send_all_i) && !empty_o && !tx_busy_i) begin
                    state_nxt = ST_ISSUE;
                    burst_nxt = send_all_i;
                    start_nxt = 1'b1;
                    data_nxt  = head;
                end
            end
            ST_ISSUE: begin
                pop       = 1'b1;
                burst_nxt = burst | send_all_i;
                state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                burst_nxt = burst | send_all_i;
                if (tx_done_i) begin
                    if (burst_nxt && !empty_o) begin
                        state_nxt = ST_ISSUE;
                        start_nxt = 1'b1;
                        data_nxt  = head;
                    end else begin
                        state_nxt = ST_IDLE;
                        burst_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                burst_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            burst      <= 1'b0;
            tx_start_o <= 1'b0;
            tx_data_o  <= '0;
            sending_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            burst      <= burst_nxt;
            tx_start_o <= start_nxt;
            tx_data_o  <= data_nxt;
            sending_o  <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a queue-based transaction model.
module tb_uart_tx_sched;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    load_i = 1'b0;
    logic [DATA_W-1:0]       load_data_i = '0;
    logic                    send_one_i = 1'b0;
    logic                    send_all_i = 1'b0;
    logic                    tx_start_o;
    logic [DATA_W-1:0]       tx_data_o;
    logic                    tx_busy_i = 1'b0;
    logic                    tx_done_i = 1'b0;
    logic [CNT_W-1:0]        count_o;
    logic                    full_o;
    logic                    empty_o;
    logic                    overflow_o;
    logic                    sending_o;
    logic [DEPTH*DATA_W-1:0] snap_o;

    uart_tx_sched #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load_i),
        .load_data_i (load_data_i),
        .send_one_i  (send_one_i),
        .send_all_i  (send_all_i),
        .tx_start_o  (tx_start_o),
        .tx_data_o   (tx_data_o),
        .tx_busy_i   (tx_busy_i),
        .tx_done_i   (tx_done_i),
        .count_o     (count_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .overflow_o  (overflow_o),
        .sending_o   (sending_o),
        .snap_o      (snap_o)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: buffer contents as a queue plus transfer bookkeeping.
    logic [DATA_W-1:0] mq[$];
    logic              m_start  = 1'b0;
    logic [DATA_W-1:0] m_data   = '0;
    logic              m_ovf    = 1'b0;
    logic              m_active = 1'b0;
    logic              m_burst  = 1'b0;

    // Transmitter model and stimulus knobs.
    int   xcnt = 0;
    logic xbusy = 1'b0;
    logic force_busy = 1'b0;
    logic rnd_mode = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [DEPTH*DATA_W-1:0] es;
        es = '0;
        for (int i = 0; i < mq.size(); i++) es[i*DATA_W +: DATA_W] = mq[i];
        check("tx_start", 64'(tx_start_o), 64'(m_start));
        check("tx_data",  64'(tx_data_o),  64'(m_data));
        check("count",    64'(count_o),    64'(mq.size()));
        check("full",     64'(full_o),     64'(mq.size() == DEPTH));
        check("empty",    64'(empty_o),    64'(mq.size() == 0));
        check("overflow", 64'(overflow_o), 64'(m_ovf));
        check("sending",  64'(sending_o),  64'(m_active));
        check("snap",     64'(snap_o),     64'(es));
    endtask

    task automatic model_reset();
        mq.delete();
        m_start  = 1'b0;
        m_data   = '0;
        m_ovf    = 1'b0;
        m_active = 1'b0;
        m_burst  = 1'b0;
    endtask

    // One cycle of the scheduler rules, applied to the inputs presented this cycle.
    task automatic model_step(input logic ld, input logic [DATA_W-1:0] d, input logic s1,
                              input logic sa, input logic busy, input logic done);
        int   sz0;
        logic issuing;
        sz0     = mq.size();
        issuing = m_start;
        m_ovf   = 1'b0;
        if (issuing) void'(mq.pop_front());
        if (ld) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else m_ovf = 1'b1;
        end
        m_start = 1'b0;
        if (!m_active) begin
            if ((s1 || sa) && sz0 > 0 && !busy) begin
                m_start  = 1'b1;
                m_data   = mq[0];
                m_burst  = sa;
                m_active = 1'b1;
            end
        end else if (issuing) begin
            m_burst = m_burst | sa;
        end else begin
            m_burst = m_burst | sa;
            if (done) begin
                if (m_burst && sz0 > 0) begin
                    m_start = 1'b1;
                    m_data  = mq[0];
                end else begin
                    m_active = 1'b0;
                    m_burst  = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic ld, input logic [DATA_W-1:0] d, input logic s1, input logic sa);
        logic rnd_busy;
        @(negedge clk);
        compare_all();
        tx_done_i = 1'b0;
        if (xcnt > 0) begin
            xcnt--;
            if (xcnt == 0) begin
                tx_done_i = 1'b1;
                xbusy     = 1'b0;
            end
        end
        if (tx_start_o) begin
            xcnt  = rnd_mode ? int'($urandom_range(2, 25)) : 20;
            xbusy = 1'b1;
        end
        if (rnd_mode && xcnt == 0 && !m_active && $urandom_range(0, 49) == 0) tx_done_i = 1'b1;
        rnd_busy    = rnd_mode && xcnt == 0 && ($urandom_range(0, 5) == 0);
        tx_busy_i   = xbusy | force_busy | rnd_busy;
        load_i      = ld;
        load_data_i = d;
        send_one_i  = s1;
        send_all_i  = sa;
        model_step(ld, d, s1, sa, tx_busy_i, tx_done_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare_all();
        load_i     = 1'b0;
        send_one_i = 1'b0;
        send_all_i = 1'b0;
        tx_done_i  = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Single send of the head byte.
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(30);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(60);

        // Burst drain of four bytes.
        for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(8'hA1 + i), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(100);

        // Overflow when full, then a load accepted in the ISSUE cycle.
        for (int i = 0; i < 4; i++) step(1'b1, DATA_W'(8'hB0 + i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        idle(25);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(100);

        // Sends discarded while empty or while the transmitter is busy.
        step(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, 8'h66, 1'b0, 1'b0);
        force_busy = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        force_busy = 1'b0;
        idle(30);

        // Burst request arriving while a single send is in flight.
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(6);
        step(1'b0, '0, 1'b0, 1'b1);
        idle(60);

        // Reset while waiting for done; the late done must not start anything.
        step(1'b1, 8'h88, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(6);
        do_reset();
        idle(40);

        // Randomized traffic with one mid-run reset.
        rnd_mode = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            step(($urandom_range(0, 9) < 4), DATA_W'($urandom),
                 ($urandom_range(0, 99) < 8), ($urandom_range(0, 99) < 3));
        end
        rnd_mode = 1'b0;
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side controller for the UART path. Queues bytes loaded from the switches into a small in-order buffer and sequences them into the byte transmitter through a start/done handshake, one byte per request or as a burst that drains the buffer. Sits between the button/switch front end and the transmitter. Exports a buffer snapshot for the seven-segment display.

## Interface
Parameters:
- `DEPTH`, default 4: buffer entries, power of two, 2..8.
- `DATA_W`, default 8: byte width.

Ports:
- `clk`, in, 1: system clock, single domain.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `load_i`, in, 1: one-cycle pulse; enqueue `load_data_i`. Already synchronized and edge-detected upstream.
- `load_data_i`, in, DATA_W: byte to enqueue (switches).
- `send_one_i`, in, 1: one-cycle pulse; transmit the head byte.
- `send_all_i`, in, 1: one-cycle pulse; transmit until the buffer is empty.
- `tx_start_o`, out, 1: one-cycle start pulse to the transmitter.
- `tx_data_o`, out, DATA_W: byte under transmission.
- `tx_busy_i`, in, 1: transmitter busy.
- `tx_done_i`, in, 1: one-cycle pulse at end of stop bit.
- `count_o`, out, $clog2(DEPTH)+1: occupied entries.
- `full_o` / `empty_o`, out, 1: buffer status.
- `overflow_o`, out, 1: one-cycle pulse when a load is dropped.
- `sending_o`, out, 1: high whenever the FSM is not IDLE.
- `snap_o`, out, DEPTH×DATA_W: entry 0 is the head. Unused entries read 0.

## Operation
- Buffer is a shift-register FIFO:
  - Load writes entry[count].
  - Pop shifts entries down by one and clears entry[DEPTH-1].
- Load while full and not popping in the same cycle: the byte is dropped and `overflow_o` pulses.
- Load and pop in the same cycle: shift, then write at count-1. This is accepted even when full. Count is unchanged.
- FSM states: IDLE, ISSUE, WAIT_DONE.
  - IDLE → ISSUE on (`send_one_i` | `send_all_i`) & !empty & !`tx_busy_i`. A send from IDLE while empty or `tx_busy_i` is discarded, not remembered.
  - `burst` flag is set from `send_all_i` on this transition.
  - ISSUE (1 cycle): `tx_start_o`=1. `tx_data_o` is loaded from entry 0, and entry 0 is popped. Always → WAIT_DONE.
  - WAIT_DONE: wait for `tx_done_i`. On done: if `burst` & !empty → ISSUE, else → IDLE and clear `burst`.
- A `send_all_i` pulse outside IDLE sets `burst`. A `send_one_i` pulse outside IDLE is ignored.
- In burst mode, loads arriving during the burst are also transmitted.
- `tx_done_i` outside WAIT_DONE is ignored.

## Timing
- Reset values:
  - FSM IDLE, `burst`=0, count 0, all entries 0.
  - `tx_start_o`=0, `tx_data_o`=0, `overflow_o`=0, `sending_o`=0.
  - `empty_o`=1, `full_o`=0.
- Request pulse in cycle n → `tx_start_o` high in cycle n+1 only. Count decrements at the end of cycle n+1.
- `tx_data_o` is registered. It is stable from the ISSUE cycle until the next ISSUE, and holds its value in IDLE.
- Burst gap: `tx_done_i` in cycle m → next `tx_start_o` in cycle m+1.
- `count_o`, `full_o`, `empty_o`, `snap_o`, `sending_o` are registered or derived from registers only. No combinational path from any input.
- Reset mid-transfer: everything returns to reset values immediately. A later `tx_done_i` from the transmitter is ignored, since the FSM is in IDLE.

## Structure
- Shared package `uart_pkg`:
  - `uart_byte_t` (logic [7:0]).
  - `tx_sched_state_e` {IDLE, ISSUE, WAIT_DONE}.
  - Constant `UART_BUF_DEPTH`=4, also used by the receive buffer and display.
- One natural sub-module: `shift_fifo`, covering storage, count, full/empty and overflow.
- FSM and handshake stay in `uart_tx_sched`.

## Test plan
- Load 0x11, 0x22, 0x33. `send_one_i` → single `tx_start_o` one cycle later with `tx_data_o`=0x11. Count 3→2; `snap_o` entry 0 = 0x22.
- Load 0xA1..0xA4, then `send_all_i` with the model returning `tx_done_i` 20 cycles after each start → four starts carrying 0xA1, 0xA2, 0xA3, 0xA4. Each start comes 1 cycle after the previous done. Then IDLE with `empty_o`=1.
- Full buffer plus a load of 0x55 → `overflow_o` pulses once and contents are unchanged. Load of 0x55 in the same cycle as ISSUE → accepted and placed in entry 3.
- `send_one_i` while empty, and `send_one_i` while `tx_busy_i`=1 in IDLE → no `tx_start_o` ever, even after busy drops.
- Single send of 2 entries, `send_all_i` during WAIT_DONE → the second byte is also sent after done.
- `rst_n` low during WAIT_DONE with 2 entries → all reset values. A later `tx_done_i` causes no start.
